// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: datapath width, the NOP used for fault slots,
// and the packed queue entry handed from fetch to decode.
// No logic, no latency, no backpressure.
package riscv_pkg;

  localparam int XLEN = 32;

  // Canonical NOP (addi x0, x0, 0) carried in the instruction slot of a fault entry.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/module_sync_fifo.sv
// Generic synchronous FIFO with a combinational head read from a register array.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must respect full/empty; a push while full is accepted only with a same-cycle pop.
//
// Ports: clock/reset (sync, active-high), flush (empties next cycle), push/push_dat,
//        pop/head_dat (head is 0 while empty), full, empty, count (occupancy 0..DEPTH).
module module_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer separates full from empty when the low bits match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/module_instruction_fetch.sv
// Fetch stage: issues word reads at the PC and queues {pc, instr, misaligned} in order for decode.
// Latency: grant in N, rvalid in N+L, if_valid in N+L+1 (queue output is registered).
// Backpressure: requests are credit-limited by inflight + queued entries; pc_stall holds the PC until a grant.
//
// Ports: clock/reset (sync, active-high); pc_addr in, pc_stall out; flush in (redirect);
//        imem_req/imem_addr out, imem_gnt/imem_rvalid/imem_rdata in;
//        if_valid/if_instr/if_pc/if_misaligned out, if_ready in.
module module_instruction_fetch #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_addr,
  output logic            pc_stall,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready,
  output logic            if_misaligned
);

  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   CREDITS = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic            locked;      // misaligned fault queued; no more pushes until redirect

  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  logic            q_push;
  logic            q_pop;
  logic [$bits(fetch_entry_t)-1:0] q_head_dat;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  logic [XLEN-1:0] tag_head;
  logic            tag_full;
  logic            tag_empty;
  logic [CW-1:0]   tag_count;
  logic            tag_unused;

  logic            aligned;
  logic            grant;
  logic            rsp;
  logic            resp_keep;
  logic            mis_push;
  logic [CW:0]     used;
  logic [CW-1:0]   rsp_dec;
  logic [CW-1:0]   grant_inc;

  assign aligned = (pc_addr[1:0] == 2'b00);
  assign q_pop   = if_valid && if_ready;

  // A head leaving this cycle frees its slot in time for a new grant; this is
  // what lets DEPTH=2 sustain one fetch per cycle at L=1. imem_gnt is not used here.
  assign used     = {1'b0, inflight} + {1'b0, q_count} - {{CW{1'b0}}, q_pop};
  assign imem_req = !reset && !flush && aligned && (used < CREDITS);
  assign imem_addr = pc_addr;
  assign grant    = imem_req && imem_gnt;
  assign pc_stall = !grant || locked;

  assign rsp       = imem_rvalid && (inflight != '0);
  assign rsp_dec   = {{(CW-1){1'b0}}, rsp};
  assign grant_inc = {{(CW-1){1'b0}}, grant};

  // Responses owed to fetches from before a redirect are swallowed while drop is nonzero.
  assign resp_keep = rsp && (drop == '0) && !flush && !reset;
  // A misaligned PC becomes a fault entry only once older fetches have drained, keeping order.
  assign mis_push  = !reset && !flush && !aligned && !locked && (inflight == '0) && !q_full;
  assign q_push    = resp_keep || mis_push;

  always_comb begin
    push_entry.pc         = tag_head;
    push_entry.instr      = imem_rdata;
    push_entry.misaligned = 1'b0;
    if (mis_push) begin
      push_entry.pc         = pc_addr;
      push_entry.instr      = NOP_INSTR;
      push_entry.misaligned = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= '0;
      drop     <= '0;
      locked   <= 1'b0;
    end else begin
      inflight <= inflight + grant_inc - rsp_dec;
      if (flush) begin
        drop   <= inflight - rsp_dec;
        locked <= 1'b0;
      end else begin
        if (rsp && (drop != '0)) drop <= drop - CNT_ONE;
        if (mis_push) locked <= 1'b1;
      end
    end
  end

  module_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .push     (grant),
    .push_dat (pc_addr),
    .pop      (resp_keep),
    .head_dat (tag_head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (tag_count)
  );

  // Tag FIFO depth matches the credit limit, so its status flags carry no new information.
  assign tag_unused = ^{tag_full, tag_empty, tag_count};

  module_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_out_queue (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .push     (q_push),
    .push_dat (push_entry),
    .pop      (q_pop),
    .head_dat (q_head_dat),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign head_entry    = fetch_entry_t'(q_head_dat);
  assign if_valid      = !q_empty;
  assign if_pc         = head_entry.pc;
  assign if_instr      = head_entry.instr;
  assign if_misaligned = head_entry.misaligned;

endmodule

// File: tb/tb_module_instruction_fetch.sv
// Directed bench for module_instruction_fetch with an in-order expected-fetch model,
// a latency-L memory model and a PC that advances by 4 whenever pc_stall is low.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_module_instruction_fetch;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam logic [31:0] MAGIC = 32'hA5A5A5A5;

  logic            clock = 1'b0;
  logic            reset;
  logic [XLEN-1:0] pc_addr;
  logic            pc_stall;
  logic            flush;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_ready;
  logic            if_misaligned;

  module_instruction_fetch #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock         (clock),
    .reset         (reset),
    .pc_addr       (pc_addr),
    .pc_stall      (pc_stall),
    .flush         (flush),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_ready      (if_ready),
    .if_misaligned (if_misaligned)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Memory: responds in grant order, exactly lat cycles after the grant, data = addr ^ MAGIC.
  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t mem_q[$];

  initial forever begin
    @(negedge clock);
    if (reset) mem_q.delete();
    else if (imem_req && imem_gnt) mem_q.push_back('{addr: imem_addr, due: cyc + lat});
  end

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clock); #1;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_q[0].addr ^ MAGIC;
        void'(mem_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  // Reference model: decode must see exactly the granted addresses since the last
  // redirect, in grant order, each carrying addr ^ MAGIC.
  logic [31:0] exp_q[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  int          grant_cnt = 0;
  bit          model_on = 0;
  bit          flush_rv = 0;
  bit          hold = 0;
  logic [31:0] hold_pc, hold_instr;
  logic        hold_mis;

  initial forever begin
    @(negedge clock);
    if (reset || !model_on) begin
      exp_q.delete();
      hold = 0;
    end else begin
      if (imem_req) chk("imem_addr_eq_pc", imem_addr, pc_addr);
      if (hold && if_valid) begin
        chk("stable_pc", if_pc, hold_pc);
        chk("stable_instr", if_instr, hold_instr);
        chk("stable_mis", {31'b0, if_misaligned}, {31'b0, hold_mis});
      end
      if (if_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_head if_pc=%h required=no entry", if_pc);
        end else begin
          chk("head_pc", if_pc, exp_q[0]);
          chk("head_instr", if_instr, exp_q[0] ^ MAGIC);
          chk("head_mis", {31'b0, if_misaligned}, 32'd0);
        end
      end
      hold       = if_valid && !if_ready && !flush;
      hold_pc    = if_pc;
      hold_instr = if_instr;
      hold_mis   = if_misaligned;
      if (if_valid && if_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (imem_req && imem_gnt) exp_q.push_back(pc_addr);
      if (flush) exp_q.delete();
    end
    if (!reset && if_valid && if_ready) begin
      pop_pc.push_back(if_pc);
      pop_instr.push_back(if_instr);
    end
    if (!reset && imem_req && imem_gnt) grant_cnt++;
    if (flush && imem_rvalid) flush_rv = 1;
  end

  // Per-cycle sampled values of the cycle just completed by cycle().
  bit          s_req, s_grant, s_valid, s_stall, s_pop;
  logic [31:0] s_addr, s_pc, s_instr, s_mis;
  int          s_cyc;
  logic [31:0] redirect_pc = '0;

  task automatic cycle();
    bit adv, fl;
    @(negedge clock);
    s_req   = imem_req;
    s_grant = imem_req && imem_gnt;
    s_valid = if_valid;
    s_stall = pc_stall;
    s_pop   = if_valid && if_ready;
    s_addr  = imem_addr;
    s_pc    = if_pc;
    s_instr = if_instr;
    s_mis   = {31'b0, if_misaligned};
    s_cyc   = cyc;
    adv = !pc_stall && !reset;
    fl  = flush;
    @(posedge clock); #1;
    flush = 1'b0;
    if (fl) pc_addr = redirect_pc;
    else if (adv) pc_addr = pc_addr + 32'd4;
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    reset   = 1'b1;
    flush   = 1'b0;
    pc_addr = pc0;
    repeat (5) cycle();
    reset = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int budget, input string nm);
    int k = 0;
    while (pop_pc.size() < target && k < budget) begin
      cycle();
      k++;
    end
    chk(nm, pop_pc.size() >= target ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic chk_pop(input string nm, input int idx, input logic [31:0] pc, input logic [31:0] ins);
    if (idx >= pop_pc.size()) begin
      checks++;
      errors++;
      $display("FAIL %s missing pop index=%0d required pc=%h", nm, idx, pc);
    end else begin
      chk({nm, "_pc"}, pop_pc[idx], pc);
      chk({nm, "_instr"}, pop_instr[idx], ins);
    end
  endtask

  int base, first_g, first_v, n, g0;

  initial begin
    reset = 1'b1; flush = 1'b0; pc_addr = '0; imem_gnt = 1'b1; if_ready = 1'b1;
    @(posedge clock); #1;

    // Reset state with pc=0 and gnt=1.
    do_reset(32'h0);
    chk("rst_imem_req", {31'b0, s_req}, 32'd0);
    chk("rst_pc_stall", {31'b0, s_stall}, 32'd1);
    chk("rst_if_valid", {31'b0, s_valid}, 32'd0);
    chk("rst_if_instr", s_instr, 32'd0);
    chk("rst_if_pc", s_pc, 32'd0);
    chk("rst_if_mis", s_mis, 32'd0);
    model_on = 1;

    // Streaming, L=1.
    base = pop_pc.size();
    first_g = -1; first_v = -1;
    cycle();
    chk("first_req", {31'b0, s_req}, 32'd1);
    chk("first_addr", s_addr, 32'h0);
    if (s_grant) first_g = s_cyc;
    for (int k = 0; k < 20 && first_v < 0; k++) begin
      cycle();
      if (s_grant && first_g < 0) first_g = s_cyc;
      if (s_valid) first_v = s_cyc;
    end
    chk("first_valid_latency", 32'(first_v - first_g), 32'd2);
    n = 0;
    repeat (8) begin
      cycle();
      if (s_pop) n++;
    end
    chk("throughput_8", 32'(n), 32'd8);
    chk_pop("stream0", base,     32'h0, 32'hA5A5A5A5);
    chk_pop("stream1", base + 1, 32'h4, 32'hA5A5A5A1);
    chk_pop("stream2", base + 2, 32'h8, 32'hA5A5A5AD);

    // Back-pressure; the reset also lands mid-stream.
    if_ready = 1'b0;
    do_reset(32'h0);
    g0 = grant_cnt;
    repeat (6) cycle();
    chk("bp_grants", 32'(grant_cnt - g0), 32'd2);
    chk("bp_req", {31'b0, s_req}, 32'd0);
    chk("bp_stall", {31'b0, s_stall}, 32'd1);
    chk("bp_valid", {31'b0, s_valid}, 32'd1);
    chk("bp_head_pc", s_pc, 32'h0);
    base = pop_pc.size();
    if_ready = 1'b1;
    wait_pops(base + 6, 40, "bp_drain");
    for (int i = 0; i < 6; i++) chk_pop("bp_order", base + i, 32'(4 * i), 32'(4 * i) ^ MAGIC);

    // Flush with two fetches in flight, L=3.
    lat = 3;
    do_reset(32'h10);
    g0 = grant_cnt;
    cycle();
    cycle();
    chk("fl_grants", 32'(grant_cnt - g0), 32'd2);
    redirect_pc = 32'h100;
    flush = 1'b1;
    cycle();
    base = pop_pc.size();
    wait_pops(base + 1, 30, "fl_wait");
    chk_pop("fl_first", base, 32'h100, 32'hA5A5A4A5);

    // Flush in the same cycle as a response, L=2.
    lat = 2;
    do_reset(32'h40);
    cycle();
    cycle();
    redirect_pc = 32'h200;
    flush = 1'b1;
    cycle();
    chk("coll_rvalid_in_flush", {31'b0, flush_rv}, 32'd1);
    base = pop_pc.size();
    wait_pops(base + 1, 30, "coll_wait");
    chk_pop("coll_first", base, 32'h200, 32'hA5A5A7A5);

    // Misaligned PC.
    model_on = 0;
    if_ready = 1'b0;
    lat = 1;
    do_reset(32'h22);
    cycle();
    chk("mis_req", {31'b0, s_req}, 32'd0);
    chk("mis_stall", {31'b0, s_stall}, 32'd1);
    cycle();
    chk("mis_valid", {31'b0, s_valid}, 32'd1);
    chk("mis_flag", s_mis, 32'd1);
    chk("mis_pc", s_pc, 32'h22);
    chk("mis_instr", s_instr, 32'h00000013);
    if_ready = 1'b1;
    cycle();
    n = 0;
    repeat (3) begin
      cycle();
      if (s_valid || !s_stall || s_req) n++;
    end
    chk("mis_hold_until_flush", 32'(n), 32'd0);
    model_on = 1;
    redirect_pc = 32'h300;
    flush = 1'b1;
    cycle();
    base = pop_pc.size();
    wait_pops(base + 1, 20, "mis_redirect_wait");
    chk_pop("mis_redirect", base, 32'h300, 32'hA5A5A6A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d required=finish", cyc);
    $fatal(1);
  end

endmodule
